// File: rtl/alu_issue.sv
// alu_issue: command FIFO feeding an external combinational ALU, with a registered result stage.
// Optional sticky carry flag is built when ALU_ISSUE_STICKY_CARRY_EN is defined.
module alu_issue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3:0]                   in_opcode,
    input  logic [WIDTH-1:0]             in_a,
    input  logic [WIDTH-1:0]             in_b,
    output logic [WIDTH-1:0]             alu_a,
    output logic [WIDTH-1:0]             alu_b,
    output logic [3:0]                   alu_opcode,
    input  logic [WIDTH-1:0]             alu_result,
    input  logic                         alu_zero,
    input  logic                         alu_carry,
    input  logic                         alu_sign,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_result,
    output logic                         out_zero,
    output logic                         out_carry,
    output logic                         out_sign,
    output logic                         out_illegal,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
`ifdef ALU_ISSUE_STICKY_CARRY_EN
    ,
    input  logic                         sticky_clr,
    output logic                         sticky_carry
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [3:0] OP_LAST_LEGAL = 4'b1001;

    logic [3:0]       op_mem_q [DEPTH];
    logic [WIDTH-1:0] a_mem_q  [DEPTH];
    logic [WIDTH-1:0] b_mem_q  [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic             out_zero_q, out_zero_d;
    logic             out_carry_q, out_carry_d;
    logic             out_sign_q, out_sign_d;
    logic             out_illegal_q, out_illegal_d;

    logic empty;
    logic push;
    logic pop;

    assign empty    = (count_q == '0);
    assign in_ready = (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    // Result register frees up either when empty or when its content is taken this edge.
    assign pop      = !empty && (!out_valid_q || out_ready);

    assign alu_a      = empty ? '0 : a_mem_q[rd_ptr_q];
    assign alu_b      = empty ? '0 : b_mem_q[rd_ptr_q];
    assign alu_opcode = empty ? '0 : op_mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_zero_d    = out_zero_q;
        out_carry_d   = out_carry_q;
        out_sign_d    = out_sign_q;
        out_illegal_d = out_illegal_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (pop) begin
            out_valid_d   = 1'b1;
            out_result_d  = alu_result;
            out_zero_d    = alu_zero;
            out_carry_d   = alu_carry;
            out_sign_d    = alu_sign;
            out_illegal_d = (alu_opcode > OP_LAST_LEGAL);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_zero_q    <= 1'b0;
            out_carry_q   <= 1'b0;
            out_sign_q    <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_zero_q    <= out_zero_d;
            out_carry_q   <= out_carry_d;
            out_sign_q    <= out_sign_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    // Storage needs no reset: entries are only visible through the reset pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem_q[wr_ptr_q] <= in_opcode;
            a_mem_q[wr_ptr_q]  <= in_a;
            b_mem_q[wr_ptr_q]  <= in_b;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_zero    = out_zero_q;
    assign out_carry   = out_carry_q;
    assign out_sign    = out_sign_q;
    assign out_illegal = out_illegal_q;
    assign fifo_count  = count_q;

`ifdef ALU_ISSUE_STICKY_CARRY_EN
    logic sticky_q, sticky_d;

    // A carry issued in the same cycle as a clear request wins.
    always_comb begin
        sticky_d = sticky_q;
        if (pop && alu_carry) sticky_d = 1'b1;
        else if (sticky_clr)  sticky_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) sticky_q <= 1'b0;
        else     sticky_q <= sticky_d;
    end

    assign sticky_carry = sticky_q;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: stand-in ALU, queue-based reference model, randomized traffic.
module tb_alu_issue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_opcode;
    logic [7:0] in_a, in_b;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_opcode;
    logic [7:0] alu_result;
    logic       alu_zero, alu_carry, alu_sign;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_zero, out_carry, out_sign, out_illegal;
    logic [2:0] fifo_count;
`ifdef ALU_ISSUE_STICKY_CARRY_EN
    logic       sticky_clr;
    logic       sticky_carry;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_a        (in_a),
        .in_b        (in_b),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .alu_carry   (alu_carry),
        .alu_sign    (alu_sign),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_carry   (out_carry),
        .out_sign    (out_sign),
        .out_illegal (out_illegal),
        .fifo_count  (fifo_count)
`ifdef ALU_ISSUE_STICKY_CARRY_EN
        ,
        .sticky_clr  (sticky_clr),
        .sticky_carry(sticky_carry)
`endif
    );

    // Stand-in ALU: returns {carry, result}; opcodes above 9 give 0.
    function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {1'b0, a} - {1'b0, b};
            4'd2:    return {1'b0, a & b};
            4'd3:    return {1'b0, a | b};
            4'd4:    return {1'b0, a ^ b};
            4'd5:    return {1'b0, ~a};
            4'd6:    return {a, 1'b0};
            4'd7:    return {a[0], 1'b0, a[7:1]};
            4'd8:    return {1'b0, a} + 9'd1;
            4'd9:    return {1'b0, a} - 9'd1;
            default: return 9'd0;
        endcase
    endfunction

    logic [8:0] alu_raw;
    assign alu_raw    = alu_fn(alu_opcode, alu_a, alu_b);
    assign alu_result = alu_raw[7:0];
    assign alu_carry  = alu_raw[8];
    assign alu_zero   = (alu_raw[7:0] == 8'd0);
    assign alu_sign   = alu_raw[7];

    // Reference model state
    cmd_t       mq[$];
    logic       m_valid, m_z, m_c, m_s, m_ill, m_sticky;
    logic [7:0] m_res;

    logic [16:0] dut_out;
    assign dut_out = {in_ready, out_valid, out_result, out_zero, out_carry, out_sign, out_illegal, fifo_count};
    cmd_t dut_head;
    assign dut_head = {alu_opcode, alu_a, alu_b};

    function automatic logic [16:0] exp_out();
        return {mq.size() != DEPTH, m_valid, m_res, m_z, m_c, m_s, m_ill, 3'(mq.size())};
    endfunction

    function automatic cmd_t exp_head();
        if (mq.size() == 0) return '0;
        return mq[0];
    endfunction

    function automatic cmd_t rand_cmd(input bit legal_only);
        cmd_t c;
        c.op = legal_only ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
        c.a  = 8'($urandom);
        c.b  = 8'($urandom);
        return c;
    endfunction

    // Drive one clock's worth of inputs, advance the model, then sample 1 time unit after the edge.
    task automatic cycle(input logic r, input logic v, input cmd_t c, input logic ordy, input logic clr);
        bit         acc, iss;
        cmd_t       h;
        logic [8:0] res;
        rst = r; in_valid = v; in_opcode = c.op; in_a = c.a; in_b = c.b; out_ready = ordy;
`ifdef ALU_ISSUE_STICKY_CARRY_EN
        sticky_clr = clr;
`endif
        if (r) begin
            mq.delete();
            m_valid = 0; m_res = 0; m_z = 0; m_c = 0; m_s = 0; m_ill = 0; m_sticky = 0;
        end else begin
            acc = v && (mq.size() != DEPTH);
            iss = (mq.size() != 0) && (!m_valid || ordy);
            if (iss) begin
                h = mq.pop_front();
                res = alu_fn(h.op, h.a, h.b);
                m_res = res[7:0]; m_c = res[8]; m_z = (res[7:0] == 0); m_s = res[7];
                m_ill = (h.op > 4'd9); m_valid = 1;
            end else if (m_valid && ordy) begin
                m_valid = 0;
            end
            m_sticky = (iss && m_c) || (m_sticky && !clr);
            if (acc) mq.push_back(c);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, '0, 0, 0);
        cycle(1, 1, rand_cmd(0), 1, 0);
        checks++;
        if (dut_out !== 17'h10000) begin
            errors++; $display("FAIL reset_outputs got %h exp %h", dut_out, 17'h10000);
        end
        checks++;
        if (dut_head !== '0) begin
            errors++; $display("FAIL reset_head got %h exp 0", dut_head);
        end
`ifdef ALU_ISSUE_STICKY_CARRY_EN
        checks++;
        if (sticky_carry !== 1'b0) begin
            errors++; $display("FAIL reset_sticky got %b exp 0", sticky_carry);
        end
`endif
        cycle(0, 0, '0, 1, 0);
    endtask

    task automatic test_add_basic();
        cycle(0, 1, {4'd0, 8'h0F, 8'h01}, 1, 0);
        checks++;
        if (out_valid !== 1'b0 || fifo_count !== 3'd1 || dut_head !== {4'd0, 8'h0F, 8'h01}) begin
            errors++; $display("FAIL add_accept got valid %b count %0d head %h exp 0 1 00f01", out_valid, fifo_count, dut_head);
        end
        cycle(0, 0, '0, 1, 0);
        checks++;
        if ({out_valid, out_result, out_zero, out_carry, out_sign, out_illegal} !== {1'b1, 8'h10, 4'b0000}) begin
            errors++; $display("FAIL add_result got v%b r%h z%b c%b s%b i%b exp v1 r10 0000",
                               out_valid, out_result, out_zero, out_carry, out_sign, out_illegal);
        end
        cycle(0, 0, '0, 1, 0);
        checks++;
        if (dut_out !== exp_out()) begin
            errors++; $display("FAIL add_drain got %h exp %h", dut_out, exp_out());
        end
    endtask

    task automatic test_carry();
        cycle(0, 1, {4'd0, 8'hFF, 8'h01}, 1, 0);
        cycle(0, 0, '0, 1, 0);
        checks++;
        if ({out_valid, out_result, out_zero, out_carry} !== {1'b1, 8'h00, 2'b11}) begin
            errors++; $display("FAIL carry_result got v%b r%h z%b c%b exp v1 r00 z1 c1", out_valid, out_result, out_zero, out_carry);
        end
`ifdef ALU_ISSUE_STICKY_CARRY_EN
        cycle(0, 0, '0, 1, 0);
        cycle(0, 1, {4'd2, 8'h0F, 8'hF0}, 1, 0);
        cycle(0, 0, '0, 1, 0);
        checks++;
        if (sticky_carry !== 1'b1) begin
            errors++; $display("FAIL sticky_hold got %b exp 1", sticky_carry);
        end
        cycle(0, 0, '0, 1, 1);
        checks++;
        if (sticky_carry !== 1'b0) begin
            errors++; $display("FAIL sticky_clear got %b exp 0", sticky_carry);
        end
        cycle(0, 1, {4'd0, 8'h80, 8'h80}, 1, 0);
        cycle(0, 0, '0, 1, 1);
        checks++;
        if (sticky_carry !== 1'b1) begin
            errors++; $display("FAIL sticky_set_wins got %b exp 1", sticky_carry);
        end
        cycle(0, 0, '0, 1, 1);
`endif
        cycle(0, 0, '0, 1, 0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) cycle(0, 1, rand_cmd(1), 0, 0);
        checks++;
        if (in_ready !== 1'b0 || fifo_count !== 3'd4 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_full got ready %b count %0d valid %b exp 0 4 1", in_ready, fifo_count, out_valid);
        end
        cycle(0, 1, rand_cmd(1), 0, 0);
        checks++;
        if (dut_out !== exp_out()) begin
            errors++; $display("FAIL bp_hold got %h exp %h", dut_out, exp_out());
        end
        // Full with pop in the same cycle: the offered command must still be refused.
        cycle(0, 1, rand_cmd(1), 1, 0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut_out !== exp_out() || dut_head !== exp_head()) begin
                errors++; $display("FAIL bp_drain[%0d] got %h/%h exp %h/%h", i, dut_out, dut_head, exp_out(), exp_head());
            end
            cycle(0, 0, '0, 1, 0);
        end
        checks++;
        if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
            errors++; $display("FAIL bp_empty got valid %b count %0d exp 0 0", out_valid, fifo_count);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            cycle(0, 1, rand_cmd(1), 1, 0);
            checks++;
            if (dut_out !== exp_out() || fifo_count > 3'd1) begin
                errors++; $display("FAIL stream[%0d] got %h exp %h", i, dut_out, exp_out());
            end
        end
        cycle(0, 0, '0, 1, 0);
        cycle(0, 0, '0, 1, 0);
    endtask

    task automatic test_illegal();
        cycle(0, 1, {4'b1100, 8'h12, 8'h34}, 1, 0);
        cycle(0, 0, '0, 1, 0);
        checks++;
        if ({out_valid, out_result, out_zero, out_illegal} !== {1'b1, 8'h00, 2'b11}) begin
            errors++; $display("FAIL illegal got v%b r%h z%b i%b exp v1 r00 z1 i1", out_valid, out_result, out_zero, out_illegal);
        end
        cycle(0, 0, '0, 1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cycle(0, 1'($urandom_range(0, 3) != 0), rand_cmd(0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 7) == 0));
            checks++;
            if (dut_out !== exp_out() || dut_head !== exp_head()) begin
                errors++; $display("FAIL random[%0d] got %h/%h exp %h/%h", i, dut_out, dut_head, exp_out(), exp_head());
            end
        end
`ifdef ALU_ISSUE_STICKY_CARRY_EN
        checks++;
        if (sticky_carry !== m_sticky) begin
            errors++; $display("FAIL random_sticky got %b exp %b", sticky_carry, m_sticky);
        end
`endif
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 20 && mq.size() + m_valid != 0; i++) cycle(0, 0, '0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, {4'd0, 8'hF0, 8'(i + 16)}, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || fifo_count !== 3'd3) begin
            errors++; $display("FAIL midflight_setup got valid %b count %0d exp 1 3", out_valid, fifo_count);
        end
        cycle(1, 1, rand_cmd(1), 1, 0);
        checks++;
        if (dut_out !== 17'h10000 || dut_head !== '0) begin
            errors++; $display("FAIL midflight_reset got %h/%h exp 10000/0", dut_out, dut_head);
        end
        cycle(0, 0, '0, 1, 0);
        checks++;
        if (dut_out !== exp_out()) begin
            errors++; $display("FAIL midflight_after got %h exp %h", dut_out, exp_out());
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
`ifdef ALU_ISSUE_STICKY_CARRY_EN
        sticky_clr = 1'b0;
`endif
        m_valid = 0; m_res = 0; m_z = 0; m_c = 0; m_s = 0; m_ill = 0; m_sticky = 0;
        test_reset();
        test_add_basic();
        test_carry();
        test_backpressure();
        test_stream();
        test_illegal();
        test_random();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
